// File: rtl/dht_sensor_emu_if.sv
// Sideband bundle for the single-wire sensor emulator (everything except the shared line).
// Latency: plain wires, no storage.
// Backpressure: none; payload/fault inputs are sampled only when the emulator latches a frame.
//   payload_i    : sensor data, byte 0 in the top byte
//   bad_csum_i   : send inverted checksum
//   busy_o       : emulator owns the line (preamble through trailing low)
//   drive_low_o  : pull-down enable, mirrors the open-drain drive
//   frame_done_o : one-cycle pulse when a frame completes
//   req_err_o    : one-cycle pulse when a host request was too short
interface dht_sensor_emu_if #(
  parameter int NUM_BYTES = 4
);
  logic [8*NUM_BYTES-1:0] payload_i;
  logic                   bad_csum_i;
  logic                   busy_o;
  logic                   drive_low_o;
  logic                   frame_done_o;
  logic                   req_err_o;

  modport master (
    output payload_i, bad_csum_i,
    input  busy_o, drive_low_o, frame_done_o, req_err_o
  );

  modport slave (
    input  payload_i, bad_csum_i,
    output busy_o, drive_low_o, frame_done_o, req_err_o
  );
endinterface

// File: rtl/dht_sensor_emu.sv
// Device-side DHT11/DHT22 single-wire emulator: detects host start, sends preamble, payload and checksum.
// Latency: line sensed through 2-FF sync (2 clk); response starts WAIT_US after the request state is entered.
// Backpressure: none; the host is ignored while a frame is being sent.
//   clk, rst : core clock, asynchronous active-high reset
//   data_io  : open-drain line, driven 0 or released (external pull-up)
//   bus      : payload/fault inputs and status outputs (dht_sensor_emu_if.slave)
module dht_sensor_emu #(
  parameter int TICK_DIV       = 50,
  parameter int NUM_BYTES      = 4,
  parameter int MSB_FIRST      = 1,
  parameter int REQ_LOW_MIN_US = 18000,
  parameter int WAIT_US        = 30,
  parameter int RESP_LOW_US    = 80,
  parameter int RESP_HIGH_US   = 80,
  parameter int BIT_LOW_US     = 50,
  parameter int BIT0_HIGH_US   = 26,
  parameter int BIT1_HIGH_US   = 70,
  parameter int END_LOW_US     = 50
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire             data_io,
  dht_sensor_emu_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NBITS  = 8 * (NUM_BYTES + 1);
  // The counter must hold the request minimum and also the longest timed state,
  // otherwise a short request threshold would saturate before the preamble ends.
  localparam int MAX_US = max2(max2(max2(REQ_LOW_MIN_US, WAIT_US), max2(RESP_LOW_US, RESP_HIGH_US)),
                               max2(max2(BIT_LOW_US, END_LOW_US), max2(BIT0_HIGH_US, BIT1_HIGH_US)));
  localparam int US_W   = $clog2(MAX_US + 1);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int IDX_W  = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE, REQ_LOW, REQ_HIGH, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q;
  logic [US_W-1:0]    us_q;
  logic [US_W-1:0]    tgt_us;
  logic               tick, expired;
  logic               line_s1, line_s2, line_q;
  logic               fall, rise;
  logic [NBITS-1:0]   sr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         csum;
  logic               cur_bit;
  logic               latch, shift, done_d, err_d;
  logic               drive_low, busy;
  logic               frame_done_q, req_err_q;

  // Line synchronizer; idle level is released (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_s1 <= 1'b1;
      line_s2 <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      line_s1 <= data_io;
      line_s2 <= line_s1;
      line_q  <= line_s2;
    end
  end

  assign fall = line_q & ~line_s2;
  assign rise = ~line_q & line_s2;

  // Microsecond timebase, restarted on every state change so each state
  // lasts exactly N*TICK_DIV clocks.
  assign tick    = (pre_q == PRE_W'(TICK_DIV - 1));
  assign expired = tick && (us_q == tgt_us);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (state_d != state_q) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (tick) begin
      pre_q <= '0;
      if (us_q != '1) us_q <= us_q + US_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) csum = csum + bus.payload_i[8*i +: 8];
    if (bus.bad_csum_i) csum = ~csum;
  end

  assign cur_bit = (MSB_FIRST != 0) ? sr_q[NBITS-1] : sr_q[0];

  // Last microsecond index of the current state's width.
  always_comb begin
    tgt_us = '1;
    case (state_q)
      REQ_HIGH:  tgt_us = US_W'(WAIT_US - 1);
      RESP_LOW:  tgt_us = US_W'(RESP_LOW_US - 1);
      RESP_HIGH: tgt_us = US_W'(RESP_HIGH_US - 1);
      BIT_LOW:   tgt_us = US_W'(BIT_LOW_US - 1);
      BIT_HIGH:  tgt_us = cur_bit ? US_W'(BIT1_HIGH_US - 1) : US_W'(BIT0_HIGH_US - 1);
      END_LOW:   tgt_us = US_W'(END_LOW_US - 1);
      default:   tgt_us = '1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    shift     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    drive_low = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) state_d = REQ_LOW;
      end
      REQ_LOW: begin
        if (rise) begin
          if (us_q >= US_W'(REQ_LOW_MIN_US)) begin
            state_d = REQ_HIGH;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      REQ_HIGH: begin
        // Expiry is checked first so a coincident host fall still gets a response.
        if (expired) begin
          state_d = RESP_LOW;
          latch   = 1'b1;
        end else if (fall) begin
          state_d = REQ_LOW;
        end
      end
      RESP_LOW: begin
        drive_low = 1'b1;
        busy      = 1'b1;
        if (expired) state_d = RESP_HIGH;
      end
      RESP_HIGH: begin
        busy = 1'b1;
        if (expired) state_d = BIT_LOW;
      end
      BIT_LOW: begin
        drive_low = 1'b1;
        busy      = 1'b1;
        if (expired) state_d = BIT_HIGH;
      end
      BIT_HIGH: begin
        busy = 1'b1;
        if (expired) begin
          shift   = 1'b1;
          state_d = (idx_q == IDX_W'(NBITS - 1)) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        drive_low = 1'b1;
        busy      = 1'b1;
        if (expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q         <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      frame_done_q <= done_d;
      req_err_q    <= err_d;
      if (latch) begin
        sr_q  <= {bus.payload_i, csum};
        idx_q <= '0;
      end else if (shift) begin
        sr_q  <= (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.drive_low_o  = drive_low;
  assign bus.busy_o       = busy;
  assign bus.frame_done_o = frame_done_q;
  assign bus.req_err_o    = req_err_q;

  assign data_io = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht_sensor_emu.sv
`timescale 1ns/1ps
module tb_dht_sensor_emu;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  line_a, line_b;
  logic host_a, host_b;
  pullup (line_a);
  pullup (line_b);
  assign line_a = host_a ? 1'b0 : 1'bz;
  assign line_b = host_b ? 1'b0 : 1'bz;

  dht_sensor_emu_if #(.NUM_BYTES(4)) bus_a ();
  dht_sensor_emu_if #(.NUM_BYTES(4)) bus_b ();

  dht_sensor_emu #(.TICK_DIV(TD), .REQ_LOW_MIN_US(20)) dut_a (
    .clk(clk), .rst(rst), .data_io(line_a), .bus(bus_a.slave));

  dht_sensor_emu #(.TICK_DIV(TD), .REQ_LOW_MIN_US(20), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .data_io(line_b), .bus(bus_b.slave));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected frame bits in transmission order.
  bit exp_q[$];

  task automatic push_frame(input logic [39:0] f, input bit msb);
    for (int i = 0; i < 40; i++) exp_q.push_back(msb ? f[39-i] : f[i]);
  endtask

  // Line monitor: measures run lengths while busy and decodes bits.
  logic        sel_b = 1'b0;
  wire         mon_line = sel_b ? line_b : line_a;
  wire         mon_busy = sel_b ? bus_b.busy_o : bus_a.busy_o;
  logic        prev_busy = 1'b0;
  logic        prev_line = 1'b1;
  int          run_len = 0, run_idx = 0, bits_rx = 0, busy_cycles = 0;
  logic [39:0] rx_frame = '0;

  task automatic end_run(input logic lvl, input int len, input int idx);
    bit b, e;
    if (idx < 2) begin
      check(idx == 0 ? "pre_low_lvl" : "pre_high_lvl", lvl, idx == 0 ? 1'b0 : 1'b1);
      check(idx == 0 ? "pre_low_w" : "pre_high_w", len, 320);
    end else if (idx % 2 == 0) begin
      check("low_lvl", lvl, 1'b0);
      check("low_w", len, 200);
    end else begin
      check("bit_high_lvl", lvl, 1'b1);
      b = (len > 192);
      check("bit_high_w", len, b ? 280 : 104);
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bit_val", b, e);
      end
      rx_frame = {rx_frame[38:0], b};
      bits_rx++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      run_len   = 0;
      run_idx   = 0;
    end else begin
      if (mon_busy) begin
        if (!prev_busy) begin
          run_len = 1; run_idx = 0; bits_rx = 0; busy_cycles = 1;
        end else begin
          busy_cycles++;
          if (mon_line == prev_line) run_len++;
          else begin
            end_run(prev_line, run_len, run_idx);
            run_idx++;
            run_len = 1;
          end
        end
      end else if (prev_busy) begin
        end_run(prev_line, run_len, run_idx);
      end
      prev_busy = mon_busy;
      prev_line = mon_line;
    end
  end

  int fd_a = 0, fd_b = 0, err_a = 0;
  bit busy_seen_a = 0, drv_seen_a = 0;
  always @(negedge clk) begin
    if (bus_a.frame_done_o) fd_a++;
    if (bus_b.frame_done_o) fd_b++;
    if (bus_a.req_err_o)    err_a++;
    if (bus_a.busy_o)       busy_seen_a = 1;
    if (bus_a.drive_low_o)  drv_seen_a = 1;
  end

  task automatic host_req(input bit on_b, input int low_us);
    @(negedge clk);
    if (on_b) host_b = 1'b1; else host_a = 1'b1;
    repeat (low_us * TD) @(negedge clk);
    if (on_b) host_b = 1'b0; else host_a = 1'b0;
  endtask

  task automatic wait_frame(input bit on_b, input int prev);
    int n = 0;
    while ((on_b ? fd_b : fd_a) == prev && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", n < 20000, 1'b1);
  endtask

  initial begin
    int lat;
    int n;
    host_a = 1'b0; host_b = 1'b0; rst = 1'b1;
    bus_a.payload_i = '0; bus_a.bad_csum_i = 1'b0;
    bus_b.payload_i = '0; bus_b.bad_csum_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy",  bus_a.busy_o, 1'b0);
    check("rst_drive", bus_a.drive_low_o, 1'b0);
    check("rst_done",  bus_a.frame_done_o, 1'b0);
    check("rst_err",   bus_a.req_err_o, 1'b0);
    check("rst_line",  line_a, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal frame, MSB first.
    bus_a.payload_i = 32'h37011A00;
    push_frame({32'h37011A00, 8'h52}, 1'b1);
    host_req(1'b0, 25);
    lat = 0;
    while (!bus_a.drive_low_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", lat, 123);
    wait_frame(1'b0, 0);
    @(negedge clk);
    check("f1_done_cnt", fd_a, 1);
    check("f1_bits", bits_rx, 40);
    check("f1_frame", rx_frame, 40'h37011A0052);
    check("f1_len", busy_cycles, 15112);
    check("f1_sb_empty", exp_q.size(), 0);
    check("f1_no_err", err_a, 0);

    // Too-short request.
    busy_seen_a = 0; drv_seen_a = 0;
    host_req(1'b0, 15);
    repeat (200) @(negedge clk);
    check("short_err", err_a, 1);
    check("short_no_drive", drv_seen_a, 1'b0);
    check("short_no_busy", busy_seen_a, 1'b0);

    // Host re-pulls during the wait, then completes a valid request; bad checksum.
    bus_a.bad_csum_i = 1'b1;
    push_frame({32'h37011A00, 8'hAD}, 1'b1);
    host_req(1'b0, 25);
    repeat (10 * TD) @(negedge clk);
    host_a = 1'b1;
    drv_seen_a = 0; busy_seen_a = 0;
    repeat (25 * TD) @(negedge clk);
    check("restart_no_drive", drv_seen_a, 1'b0);
    check("restart_no_busy", busy_seen_a, 1'b0);
    check("restart_no_err", err_a, 1);
    host_a = 1'b0;
    wait_frame(1'b0, 1);
    @(negedge clk);
    check("f2_done_cnt", fd_a, 2);
    check("f2_bits", bits_rx, 40);
    check("f2_csum", rx_frame[7:0], 8'hAD);
    check("f2_payload", rx_frame[39:8], 32'h37011A00);
    check("f2_sb_empty", exp_q.size(), 0);
    bus_a.bad_csum_i = 1'b0;

    // LSB-first instance.
    sel_b = 1'b1;
    bus_b.payload_i = 32'h00000001;
    push_frame({32'h00000001, 8'h01}, 1'b0);
    host_req(1'b1, 25);
    wait_frame(1'b1, 0);
    @(negedge clk);
    check("lsb_done_cnt", fd_b, 1);
    check("lsb_bits", bits_rx, 40);
    check("lsb_first_bit", rx_frame[39], 1'b1);
    check("lsb_len", busy_cycles, 13352);
    check("lsb_sb_empty", exp_q.size(), 0);
    sel_b = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during bit 12.
    push_frame({32'h37011A00, 8'h52}, 1'b1);
    host_req(1'b0, 25);
    n = 0;
    while (bits_rx != 12 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("bit12_timeout", n < 20000, 1'b1);
    repeat (5) @(negedge clk);
    check("pre_rst_drive", bus_a.drive_low_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_drive", bus_a.drive_low_o, 1'b0);
    check("mid_rst_busy", bus_a.busy_o, 1'b0);
    check("mid_rst_line", line_a, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", fd_a, 2);

    bus_a.payload_i = 32'h00000000;
    push_frame(40'h0, 1'b1);
    host_req(1'b0, 25);
    wait_frame(1'b0, 2);
    @(negedge clk);
    check("f3_done_cnt", fd_a, 3);
    check("f3_bits", bits_rx, 40);
    check("f3_frame", rx_frame, 40'h0);
    check("f3_len", busy_cycles, 13000);
    check("f3_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
